// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the cpu controller
package cpu_pkg;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
        S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_WR_REG,
        S_ADDR, S_LD_DA, S_MEM_RD, S_WB_MEM, S_PASS, S_WR_MEM,
        S_HALT
    } state_t;

endpackage

// File: rtl/instr_dec.sv
// rtl/instr_dec.sv - combinational field split and sign extension of the instruction register
module instr_dec (
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];
    assign sh     = ir[4:3];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - fetch/decode sequencer owning IR, PC and DA; Moore decode of datapath controls
module cpu_controller #(
    parameter int unsigned     PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     mdata,
    input  logic [15:0]     datapath_out,
    output logic [3:0]      vsel,
    output logic [2:0]      writenum,
    output logic [2:0]      readnum,
    output logic            write,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            asel,
    output logic            bsel,
    output logic [1:0]      shift,
    output logic [1:0]      ALUop,
    output logic [15:0]     sximm5,
    output logic [15:0]     sximm8,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] mem_addr,
    output logic [1:0]      mem_cmd,
    output logic            halted
);
    import cpu_pkg::*;

    state_t          state, state_next;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc, da;
    logic [2:0]      opcode, rn, rd, rm;
    logic [1:0]      op, sh;
    logic            is_mem;
    logic            unused_bits;

    instr_dec u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm5 (sximm5),
        .sximm8 (sximm8)
    );

    assign PC          = pc;
    assign is_mem      = (opcode == OPC_LDR) || (opcode == OPC_STR);
    assign unused_bits = ^datapath_out[15:PC_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
            pc    <= RESET_PC;
            da    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == S_IF2)    ir <= mdata;
            if (state == S_UPD_PC) pc <= pc + PC_W'(1);
            if (state == S_LD_DA)  da <= datapath_out[PC_W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        vsel       = '0;
        writenum   = '0;
        readnum    = '0;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        shift      = 2'b00;
        ALUop      = 2'b00;
        mem_cmd    = MEM_NONE;
        mem_addr   = pc;
        halted     = 1'b0;
        case (state)
            S_RST:    state_next = S_IF1;
            S_IF1: begin
                mem_cmd    = MEM_RD;
                state_next = S_IF2;
            end
            S_IF2: begin
                mem_cmd    = MEM_RD;
                state_next = S_UPD_PC;
            end
            S_UPD_PC: state_next = S_DECODE;
            S_DECODE: begin
                case ({opcode, op})
                    {OPC_MOV, OP_MOV_IMM}:                      state_next = S_WR_IMM;
                    {OPC_MOV, OP_MOV_REG}, {OPC_ALU, OP_MVN}:   state_next = S_GET_B;
                    {OPC_ALU, OP_ADD}, {OPC_ALU, OP_CMP},
                    {OPC_ALU, OP_AND}:                          state_next = S_GET_A;
                    {OPC_LDR, OP_MEM}, {OPC_STR, OP_MEM}:       state_next = S_GET_A;
                    default: state_next = (opcode == OPC_HALT) ? S_HALT : S_IF1;
                endcase
            end
            S_WR_IMM: begin
                vsel       = VSEL_IMM;
                writenum   = rn;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = is_mem ? S_ADDR : S_GET_B;
            end
            S_GET_B: begin
                loadb = 1'b1;
                // STR reuses GET_B to fetch the store data; its IR[4:3] are offset bits, not a shift
                if (opcode == OPC_STR) begin
                    readnum    = rd;
                    state_next = S_PASS;
                end else begin
                    readnum    = rm;
                    shift      = sh;
                    state_next = S_ALU;
                end
            end
            S_ALU: begin
                loadc      = 1'b1;
                asel       = (opcode == OPC_MOV);
                ALUop      = (opcode == OPC_MOV) ? 2'b00 : op;
                state_next = (opcode == OPC_ALU && op == OP_CMP) ? S_IF1 : S_WR_REG;
            end
            S_WR_REG: begin
                vsel       = VSEL_C;
                writenum   = rd;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_ADDR: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_LD_DA;
            end
            S_LD_DA:  state_next = (opcode == OPC_STR) ? S_GET_B : S_MEM_RD;
            S_MEM_RD: begin
                mem_cmd    = MEM_RD;
                mem_addr   = da;
                state_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                mem_cmd    = MEM_RD;
                mem_addr   = da;
                vsel       = VSEL_MDATA;
                writenum   = rd;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_PASS: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_WR_MEM;
            end
            S_WR_MEM: begin
                mem_cmd    = MEM_WR;
                mem_addr   = da;
                state_next = S_IF1;
            end
            S_HALT:   halted = 1'b1;
            default:  state_next = S_RST;
        endcase
    end

endmodule
